// File: rtl/c3_heap_issuer_if.sv
// Request, C3 command/result and response signal bundle for c3_heap_issuer.
interface c3_heap_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic [4:0]  req_tag;

    logic        c3_in_v;
    logic [4:0]  c3_rd;
    logic [2:0]  c3_vrd1;
    logic [2:0]  c3_vrd2;
    logic [31:0] c3_in_data;
    logic        c3_out_v;
    logic [4:0]  c3_out_rd;
    logic [31:0] c3_out_data;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [4:0]  rsp_tag;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;

    modport slave (
        input  req_valid, req_op, req_data, req_tag,
        output req_ready,
        output c3_in_v, c3_rd, c3_vrd1, c3_vrd2, c3_in_data,
        input  c3_out_v, c3_out_rd, c3_out_data,
        output rsp_valid, rsp_tag, rsp_data, rsp_status,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_op, req_data, req_tag,
        input  req_ready,
        input  c3_in_v, c3_rd, c3_vrd1, c3_vrd2, c3_in_data,
        output c3_out_v, c3_out_rd, c3_out_data,
        input  rsp_valid, rsp_tag, rsp_data, rsp_status,
        output rsp_ready
    );
endinterface

// File: rtl/c3_heap_issuer.sv
// Front end for the C3 heap unit: issues push/pop commands, filters full/empty
// locally via a shadow occupancy, and returns in-order responses from a completion queue.
module c3_heap_issuer #(
    parameter int PIPE_CYCLES = 5,
    parameter int HEAP_SIZE   = 256,
    parameter int RESP_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    c3_heap_issuer_if.slave   bus,
    output logic [8:0]        occupancy,
    output logic              proto_err
);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {ST_OK = 2'd0, ST_EMPTY = 2'd1, ST_FULL = 2'd2, ST_ERR = 2'd3} status_t;

    logic [4:0]            e_tag    [RESP_DEPTH];
    logic [31:0]           e_data   [RESP_DEPTH];
    status_t               e_status [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] e_done, e_issued, e_pop;

    logic [PW-1:0]          head, tail;
    logic [CW-1:0]          count;
    logic                   run_q;
    logic [PIPE_CYCLES-1:0] expect_q;
    logic [8:0]             occ_q;

    logic        c3_in_v_q;
    logic [4:0]  c3_rd_q;
    logic [2:0]  c3_vrd1_q;
    logic [31:0] c3_in_data_q;

    logic is_push, is_pop, push_ok, pop_ok, accept, issue, drain, exp_hit;
    logic          pend_found;
    logic [PW-1:0] pend_idx, scan_idx;

    assign is_push = (bus.req_op == 2'd1);
    assign is_pop  = (bus.req_op == 2'd2);
    assign push_ok = is_push && (occ_q != 9'(HEAP_SIZE));
    assign pop_ok  = is_pop && (occ_q != 9'd0);
    assign accept  = bus.req_valid && bus.req_ready;
    assign issue   = accept && (push_ok || pop_ok);
    assign drain   = bus.rsp_valid && bus.rsp_ready;
    assign exp_hit = expect_q[PIPE_CYCLES-1];

    // C3 results return in issue order, so the oldest issued-but-not-done entry
    // from head is the one the next result belongs to; local rejects are skipped.
    always_comb begin
        pend_found = 1'b0;
        pend_idx   = '0;
        scan_idx   = '0;
        for (int unsigned k = 0; k < RESP_DEPTH; k++) begin
            scan_idx = head + PW'(k);
            if (!pend_found && (CW'(k) < count) && e_issued[scan_idx] && !e_done[scan_idx]) begin
                pend_found = 1'b1;
                pend_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < RESP_DEPTH; i++) begin
                e_tag[i]    <= '0;
                e_data[i]   <= '0;
                e_status[i] <= ST_OK;
            end
            e_done       <= '0;
            e_issued     <= '0;
            e_pop        <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            run_q        <= 1'b0;
            expect_q     <= '0;
            occ_q        <= '0;
            proto_err    <= 1'b0;
            c3_in_v_q    <= 1'b0;
            c3_rd_q      <= '0;
            c3_vrd1_q    <= '0;
            c3_in_data_q <= '0;
        end else begin
            run_q    <= 1'b1;
            expect_q <= (expect_q << 1) | PIPE_CYCLES'(c3_in_v_q);

            c3_in_v_q    <= issue;
            c3_rd_q      <= issue ? bus.req_tag : '0;
            c3_vrd1_q    <= issue ? {1'b0, bus.req_op} : '0;
            c3_in_data_q <= (issue && is_push) ? bus.req_data : '0;

            if (accept) begin
                e_tag[tail]    <= bus.req_tag;
                e_data[tail]   <= '0;
                e_pop[tail]    <= is_pop;
                e_issued[tail] <= issue;
                e_done[tail]   <= !issue;
                e_status[tail] <= issue ? ST_OK : (is_push ? ST_FULL : (is_pop ? ST_EMPTY : ST_ERR));
                tail           <= tail + PW'(1);
                if (push_ok)
                    occ_q <= occ_q + 9'd1;
                else if (pop_ok)
                    occ_q <= occ_q - 9'd1;
            end

            if (exp_hit && pend_found) begin
                e_done[pend_idx] <= 1'b1;
                if (bus.c3_out_v && (bus.c3_out_rd == e_tag[pend_idx])) begin
                    e_status[pend_idx] <= ST_OK;
                    e_data[pend_idx]   <= e_pop[pend_idx] ? bus.c3_out_data : '0;
                end else begin
                    e_status[pend_idx] <= ST_ERR;
                    e_data[pend_idx]   <= '0;
                    proto_err          <= 1'b1;
                end
            end else if (exp_hit || bus.c3_out_v) begin
                proto_err <= 1'b1;
            end

            if (drain)
                head <= head + PW'(1);

            unique case ({accept, drain})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.req_ready  = run_q && (count < CW'(RESP_DEPTH));
    assign bus.c3_in_v    = c3_in_v_q;
    assign bus.c3_rd      = c3_rd_q;
    assign bus.c3_vrd1    = c3_vrd1_q;
    assign bus.c3_vrd2    = '0;
    assign bus.c3_in_data = c3_in_data_q;
    assign bus.rsp_valid  = (count != '0) && e_done[head];
    assign bus.rsp_tag    = bus.rsp_valid ? e_tag[head] : '0;
    assign bus.rsp_data   = bus.rsp_valid ? e_data[head] : '0;
    assign bus.rsp_status = bus.rsp_valid ? e_status[head] : ST_OK;
    assign occupancy      = occ_q;
endmodule

// File: tb/tb_c3_heap_issuer.sv
// Directed bench for c3_heap_issuer with a fixed-latency max-heap C3 model and fault injection.
module tb_c3_heap_issuer;
    localparam int P = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] occupancy;
    logic       proto_err;

    always #5 clk = ~clk;

    c3_heap_issuer_if bus();

    c3_heap_issuer #(.PIPE_CYCLES(P), .HEAP_SIZE(256), .RESP_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .bus(bus), .occupancy(occupancy), .proto_err(proto_err)
    );

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // C3 model: P-stage pipeline; pops return the current maximum.
    logic [P-1:0] pv;
    logic [4:0]   prd [P];
    logic [31:0]  pd  [P];
    logic [31:0]  hq  [$];
    logic inj_bad = 1'b0, inj_drop = 1'b0, inj_stray = 1'b0;

    function automatic logic [31:0] heap_pop();
        int bi;
        logic [31:0] m;
        if (hq.size() == 0) return '0;
        bi = 0;
        for (int j = 1; j < hq.size(); j++)
            if (hq[j] > hq[bi]) bi = j;
        m = hq[bi];
        hq.delete(bi);
        return m;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pv <= '0;
            for (int j = 0; j < P; j++) begin
                prd[j] <= '0;
                pd[j]  <= '0;
            end
            hq.delete();
        end else begin
            pv <= {pv[P-2:0], bus.c3_in_v};
            for (int j = P - 1; j > 0; j--) begin
                prd[j] <= prd[j-1];
                pd[j]  <= pd[j-1];
            end
            prd[0] <= bus.c3_rd;
            if (bus.c3_in_v && bus.c3_vrd1 == 3'd2)
                pd[0] <= heap_pop();
            else begin
                pd[0] <= '0;
                if (bus.c3_in_v && bus.c3_vrd1 == 3'd1) hq.push_back(bus.c3_in_data);
            end
        end
    end

    assign bus.c3_out_v    = (pv[P-1] && !inj_drop) || inj_stray;
    assign bus.c3_out_rd   = prd[P-1] ^ {4'b0, inj_bad};
    assign bus.c3_out_data = pd[P-1];

    int issue_cnt = 0, rsp_cnt = 0, vrd2_bad = 0, popdata_bad = 0;
    always @(negedge clk) begin
        if (bus.c3_in_v) issue_cnt++;
        if (bus.rsp_valid && bus.rsp_ready) rsp_cnt++;
        if (bus.c3_vrd2 != 3'd0) vrd2_bad++;
        if (bus.c3_in_v && bus.c3_vrd1 == 3'd2 && bus.c3_in_data != 32'd0) popdata_bad++;
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  tag;
        logic [1:0]  st;
        logic [31:0] rd;
        logic [8:0]  occ;
        int          lat;
        int          iss;
    } vec_t;
    vec_t tab[16];

    task automatic send(input logic [1:0] op, input logic [31:0] d, input logic [4:0] t);
        int n = 0;
        logic rdy;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_data = d; bus.req_tag = t;
        do begin
            @(negedge clk); rdy = bus.req_ready;
            @(posedge clk); #1; n++;
        end while (!rdy && n < 200);
        if (!rdy) begin
            nvec++; nbad++;
            $display("FAIL send_timeout: tag %0d never accepted", t);
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat = 0;
        int i0 = issue_cnt;
        send(v.op, v.data, v.tag);
        chk({nm, ".occ"}, 32'(occupancy), 32'(v.occ));
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, ".lat"}, 32'(lat), 32'(v.lat));
        chk({nm, ".tag"}, 32'(bus.rsp_tag), 32'(v.tag));
        chk({nm, ".status"}, 32'(bus.rsp_status), 32'(v.st));
        chk({nm, ".data"}, bus.rsp_data, v.rd);
        @(posedge clk); #1;
        chk({nm, ".issued"}, 32'(issue_cnt - i0), 32'(v.iss));
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
    endtask

    logic [1:0]  bp_op  [8] = '{2'd1, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1};
    logic [31:0] bp_d   [8] = '{32'h11, 32'hFFFF, 32'h0, 32'h0, 32'h22, 32'h44, 32'h0, 32'h33};
    logic [1:0]  bp_st  [8] = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [31:0] bp_rd  [8] = '{32'h0, 32'h11, 32'h0, 32'h0, 32'h0, 32'h0, 32'h44, 32'h0};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0, i0, k, n;
        tab[0]  = '{2'd1, 32'h10,       5'd1,  2'd0, 32'h0,        9'd1,   6, 1};
        tab[1]  = '{2'd1, 32'h30,       5'd2,  2'd0, 32'h0,        9'd2,   6, 1};
        tab[2]  = '{2'd1, 32'h20,       5'd3,  2'd0, 32'h0,        9'd3,   6, 1};
        tab[3]  = '{2'd2, 32'hFFFF,     5'd4,  2'd0, 32'h30,       9'd2,   6, 1};
        tab[4]  = '{2'd2, 32'h0,        5'd5,  2'd0, 32'h20,       9'd1,   6, 1};
        tab[5]  = '{2'd2, 32'hABCD,     5'd6,  2'd0, 32'h10,       9'd0,   6, 1};
        tab[6]  = '{2'd2, 32'h0,        5'd9,  2'd1, 32'h0,        9'd0,   0, 0};
        tab[7]  = '{2'd0, 32'h5,        5'd10, 2'd3, 32'h0,        9'd0,   0, 0};
        tab[8]  = '{2'd3, 32'h6,        5'd11, 2'd3, 32'h0,        9'd0,   0, 0};
        tab[9]  = '{2'd1, 32'hDEADBEEF, 5'd12, 2'd0, 32'h0,        9'd1,   6, 1};
        tab[10] = '{2'd2, 32'h0,        5'd13, 2'd0, 32'hDEADBEEF, 9'd0,   6, 1};
        tab[11] = '{2'd1, 32'h999,      5'd7,  2'd2, 32'h0,        9'd256, 0, 0};
        tab[12] = '{2'd3, 32'h0,        5'd8,  2'd3, 32'h0,        9'd256, 0, 0};
        tab[13] = '{2'd2, 32'h0,        5'd14, 2'd0, 32'hFF,       9'd255, 6, 1};
        tab[14] = '{2'd1, 32'h1234,     5'd15, 2'd0, 32'h0,        9'd256, 6, 1};
        tab[15] = '{2'd1, 32'h4321,     5'd16, 2'd2, 32'h0,        9'd256, 0, 0};

        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_data = '0; bus.req_tag = '0;
        bus.rsp_ready = 1'b1;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.req_ready", 32'(bus.req_ready), 0);
        chk("rst.c3_cmd", {bus.c3_in_v, bus.c3_rd, bus.c3_vrd1, bus.c3_vrd2}, 0);
        chk("rst.c3_in_data", bus.c3_in_data, 0);
        chk("rst.rsp", {bus.rsp_valid, bus.rsp_tag, bus.rsp_status}, 0);
        chk("rst.rsp_data", bus.rsp_data, 0);
        chk("rst.occ_err", {occupancy, proto_err}, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        chk("release.req_ready", 32'(bus.req_ready), 1);

        for (int i = 0; i <= 10; i++) run_vec(tab[i], $sformatf("v%0d", i));

        // Fill the heap to capacity with values 0..255.
        r0 = rsp_cnt;
        for (int i = 0; i < 256; i++) send(2'd1, 32'(i), 5'(i));
        repeat (20) @(posedge clk);
        #1;
        chk("fill.occ", 32'(occupancy), 256);
        chk("fill.rsps", 32'(rsp_cnt - r0), 256);
        for (int i = 11; i <= 15; i++) run_vec(tab[i], $sformatf("v%0d", i));

        // Backpressure: eight mixed requests with the response port stalled.
        do_reset();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(bp_op[i], bp_d[i], 5'(i + 1));
        chk("bp.req_ready_full", 32'(bus.req_ready), 0);
        chk("bp.occ", 32'(occupancy), 2);
        repeat (10) @(posedge clk);
        #1;
        for (int h = 0; h < 3; h++) begin
            chk($sformatf("bp.hold%0d", h), {bus.rsp_valid, bus.rsp_tag, bus.rsp_status}, {24'h0, 1'b1, 5'd1, 2'd0});
            chk($sformatf("bp.hold%0d.data", h), bus.rsp_data, 0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        k = 0; n = 0;
        while (k < 8 && n < 100) begin
            if (bus.rsp_valid) begin
                chk($sformatf("bp.r%0d.tag", k), 32'(bus.rsp_tag), 32'(k + 1));
                chk($sformatf("bp.r%0d.status", k), 32'(bus.rsp_status), 32'(bp_st[k]));
                chk($sformatf("bp.r%0d.data", k), bus.rsp_data, bp_rd[k]);
                k++;
            end
            @(posedge clk); #1; n++;
        end
        chk("bp.count", 32'(k), 8);
        chk("bp.after", {bus.req_ready, bus.rsp_valid}, 32'b10);

        // Protocol errors: wrong result tag, then a missing result.
        do_reset();
        chk("perr.clear", 32'(proto_err), 0);
        inj_bad = 1'b1;
        run_vec('{2'd1, 32'h5, 5'd3, 2'd3, 32'h0, 9'd1, 6, 1}, "perr.badrd");
        inj_bad = 1'b0;
        chk("perr.set", 32'(proto_err), 1);
        run_vec('{2'd1, 32'h6, 5'd4, 2'd0, 32'h0, 9'd2, 6, 1}, "perr.next_ok");
        chk("perr.sticky", 32'(proto_err), 1);
        inj_drop = 1'b1;
        run_vec('{2'd2, 32'h0, 5'd5, 2'd3, 32'h0, 9'd1, 6, 1}, "perr.missing");
        inj_drop = 1'b0;

        // Stray result with nothing outstanding.
        do_reset();
        chk("stray.clear", 32'(proto_err), 0);
        r0 = rsp_cnt;
        inj_stray = 1'b1;
        @(posedge clk); #1;
        inj_stray = 1'b0;
        chk("stray.proto_err", 32'(proto_err), 1);
        repeat (5) @(posedge clk);
        #1;
        chk("stray.no_rsp", 32'(rsp_cnt - r0), 0);
        chk("stray.state", {bus.rsp_valid, occupancy}, 0);

        // Reset with three requests in flight.
        do_reset();
        send(2'd1, 32'h7, 5'd1);
        send(2'd1, 32'h8, 5'd2);
        send(2'd2, 32'h0, 5'd3);
        chk("mid.occ", 32'(occupancy), 1);
        chk("mid.c3_in_v", 32'(bus.c3_in_v), 1);
        reset = 1'b0;
        #1;
        chk("mid.rst.ctl", {bus.req_ready, bus.c3_in_v, bus.rsp_valid, proto_err}, 0);
        chk("mid.rst.cmd", {bus.c3_rd, bus.c3_vrd1, occupancy}, 0);
        chk("mid.rst.rsp", {bus.rsp_tag, bus.rsp_status}, 0);
        r0 = rsp_cnt; i0 = issue_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("mid.no_rsp", 32'(rsp_cnt - r0), 0);
        chk("mid.no_issue", 32'(issue_cnt - i0), 0);
        chk("mid.req_ready", 32'(bus.req_ready), 1);

        chk("vrd2_zero", 32'(vrd2_bad), 0);
        chk("pop_in_data_zero", 32'(popdata_bad), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule

// File: doc/c3_heap_issuer.md
# c3_heap_issuer

Initiator-side front end for the C3 custom-instruction heap unit. Accepts push/pop requests from the core on a valid/ready port and issues them on the C3 command interface (`in_v/rd/vrd1/vrd2/in_data`). It collects the fixed-latency C3 results (`out_v/out_rd/out_data`) and returns one in-order, back-pressurable response per request. It keeps a shadow heap occupancy so pushes to a full heap and pops from an empty heap never reach the C3 unit.

## Interface
- `PIPE_CYCLES`, 5, C3 pipeline latency from `in_v` to `out_v`.
- `HEAP_SIZE`, 256, heap capacity; bounds the shadow occupancy.
- `RESP_DEPTH`, 8, completion-queue entries (power of 2).
- `clk` in 1, the single clock; all state is on its rising edge.
- `reset` in 1, asynchronous, active-low (0 = reset).
- `req_valid` in 1, request offered.
- `req_ready` out 1, request accepted when both `req_valid` and `req_ready` are high.
- `req_op` in 2, request opcode: 1 = push, 2 = pop, 0/3 = illegal.
- `req_data` in 32, push value.
- `req_tag` in 5, request tag; returned on `rsp_tag` and driven on `c3_rd`.
- `c3_in_v` out 1, command valid to C3.
- `c3_rd` out 5, command tag.
- `c3_vrd1` out 3, opcode (1 = push, 2 = pop).
- `c3_vrd2` out 3, always 0.
- `c3_in_data` out 32, push data (0 for pop).
- `c3_out_v` in 1, C3 result valid.
- `c3_out_rd` in 5, C3 result tag.
- `c3_out_data` in 32, C3 result data.
- `rsp_valid` out 1, response valid.
- `rsp_ready` in 1, response accepted.
- `rsp_tag` out 5, response tag.
- `rsp_data` out 32, popped value; 0 otherwise.
- `rsp_status` out 2, response status: 0 OK, 1 EMPTY, 2 FULL, 3 ERR.
- `occupancy` out 9, shadow heap count.
- `proto_err` out 1, sticky C3 protocol-violation flag.

## Operation
- **Completion queue:** circular, `RESP_DEPTH` entries. Each entry holds {tag, data, status, done}.
  - Head, tail and c3-pending pointers.
  - Count is held in a `$clog2(RESP_DEPTH)+1`-bit register.
- **`req_ready`** = (count < `RESP_DEPTH`), from registered count only. A same-cycle drain does not free a slot.
- **Accept: push with occupancy < `HEAP_SIZE`.** Allocate entry (done = 0) and issue to C3. Occupancy +1.
- **Accept: pop with occupancy > 0.** Allocate entry (done = 0) and issue to C3. Occupancy −1.
- **Accept: push with occupancy == `HEAP_SIZE`.** Entry is done immediately with status FULL and data 0. No issue.
- **Accept: pop with occupancy == 0.** Entry is done immediately with status EMPTY and data 0. No issue.
- **Accept: illegal op.** Entry is done immediately with status ERR and data 0. No issue. Occupancy unchanged.
- **Issue:** registered. `c3_in_v`=1 for exactly one cycle per issued request, with `c3_rd`=tag, `c3_vrd1`=op, `c3_in_data`=data or 0.
- **Expectation tracking:** a `PIPE_CYCLES`-bit expect shift register mirrors `c3_in_v`. The pending pointer advances past local-complete entries to the oldest issued, not-done entry.
- **Result capture, normal:** on `c3_out_v` with the expect bit set, the pending entry becomes done.
  - Status OK. Data = `c3_out_data` for pop, 0 for push.
  - If `c3_out_rd` ≠ entry tag: status ERR and `proto_err` set.
- **Result capture, missing:** expect bit set with `c3_out_v`=0 → pending entry done with status ERR, data 0; `proto_err` set.
- **Result capture, unexpected:** `c3_out_v` with expect bit clear → result dropped; `proto_err` set.
- **Drain:** `rsp_valid` = head entry done. The head pops when `rsp_valid && rsp_ready`. Payload is stable while `rsp_valid && !rsp_ready`.
- **Ordering:** responses leave strictly in acceptance order regardless of local or C3 completion.
- **Widths:** occupancy saturates logically at 0 and `HEAP_SIZE` by the checks above. Pointers wrap modulo `RESP_DEPTH`.

## Timing
- **Reset values (reset low):** `req_ready`, `c3_in_v`, `c3_rd`, `c3_vrd1`, `c3_vrd2`, `c3_in_data`, `rsp_valid`, `rsp_tag`, `rsp_data`, `rsp_status`, `occupancy` and `proto_err` all = 0. Queue and expect register cleared.
- **After reset release:** `req_ready`=1 from the first edge.
- **Reset mid-operation:** all in-flight and queued requests are discarded with no responses. The C3 unit shares this reset.
- **C3 request:** accepted at edge T → `c3_in_v` high in cycle T+1 → `c3_out_v` in cycle T+1+`PIPE_CYCLES` → `rsp_valid` earliest cycle T+2+`PIPE_CYCLES` if at head.
- **Local-reject request:** `rsp_valid` earliest cycle T+1 if at head.
- **Throughput:** one accept, one issue, one capture and one drain per cycle, all simultaneously.
- **Occupancy:** updates at the accept edge, so back-to-back requests see each other's effect.

## Test plan
- **Push then pop:** reset; push 0x10, 0x30, 0x20 (tags 1, 2, 3); pop ×3 (tags 4, 5, 6) → OK responses in tag order, pops return 0x30, 0x20, 0x10; `occupancy` 3 → 0; push `rsp_valid` 7 cycles after accept.
- **Empty pop:** pop on empty heap, tag 9 → `rsp_status`=1, `rsp_data`=0 one cycle after accept; `c3_in_v` never asserted.
- **Full heap with an illegal op:** fill with 256 pushes, push tag 7 → status FULL; `req_op`=3 → status ERR; `occupancy` stays 256.
- **Backpressure ordering:** hold `rsp_ready`=0 and issue 8 mixed requests → `req_ready` drops after the 8th and payload holds. Release → 8 responses in order, then `req_ready`=1.
- **Protocol errors:**
  - Wrong `c3_out_rd` → status ERR, `proto_err`=1 held until reset.
  - Stray `c3_out_v` with nothing pending → `proto_err`=1, no response.
- **Mid-operation reset:** assert reset with 3 requests in flight → all outputs 0 asynchronously; no responses appear after release.
